// File: rtl/vec_stepper_pkg.sv
// Shared types, the stimulus table and the golden model for vec_stepper.
package vec_pkg;

    typedef enum logic [1:0] {
        VS_IDLE  = 2'd0,
        VS_APPLY = 2'd1,
        VS_DONE  = 2'd2
    } vs_state_t;

    // Stimulus vectors {a,b,c,d}; only the first NUM_VEC entries are used.
    localparam logic [3:0] VEC_TABLE [16] = '{
        4'b1101, 4'b0101, 4'b1101, 4'b1100,
        4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0000, 4'b0000, 4'b0000, 4'b0000
    };

    // Reference for the gate network y = ((a & b) | c) & d.
    function automatic logic golden_y(input logic [3:0] v);
        return ((v[3] & v[2]) | v[1]) & v[0];
    endfunction

endpackage

// File: rtl/vec_stepper_hold_timer.sv
// Loadable down-counter that times one hold window per vector.
// expire is high during the last cycle of the window, so the owner can
// sample and reload on the edge that closes it.
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(HOLD_CYCLES);

    logic [CW-1:0] remain;
    logic          running;

    // Count down from HOLD_CYCLES-1 after a load; stop once the window closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            remain  <= {CW{1'b0}};
            running <= 1'b0;
        end else if (load) begin
            remain  <= CW'(HOLD_CYCLES - 1);
            running <= 1'b1;
        end else if (running) begin
            if (remain == {CW{1'b0}}) begin
                running <= 1'b0;
            end else begin
                remain <= remain - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            remain  <= remain;
            running <= running;
        end
    end

    assign expire = running && (remain == {CW{1'b0}});

endmodule

// File: rtl/vec_stepper.sv
// Steps through VEC_TABLE, holds each vector for HOLD_CYCLES clocks, samples
// the gate network's output at the end of each hold and scores it against
// the golden model.
module vec_stepper
    import vec_pkg::*;
#(
    parameter int NUM_VEC     = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [3:0]                   vec,
    input  logic                         y_in,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(NUM_VEC+1)-1:0] err_count,
    output logic                         sample_valid,
    output logic                         sample_y,
    output logic                         sample_exp,
    output logic [3:0]                   sample_idx
);

    localparam int EW = $clog2(NUM_VEC + 1);

    vs_state_t     state, state_nx;
    logic [3:0]    idx, idx_nx;
    logic [3:0]    vec_nx;
    logic [EW-1:0] err_nx;
    logic          sv_nx, sy_nx, se_nx;
    logic [3:0]    si_nx;
    logic          load;
    logic          expire;
    logic          exp_y;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expire (expire)
    );

    assign exp_y = golden_y(VEC_TABLE[idx]);

    // Next-state, next-vector and scoring decisions.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        vec_nx   = vec;
        err_nx   = err_count;
        sv_nx    = 1'b0;
        sy_nx    = sample_y;
        se_nx    = sample_exp;
        si_nx    = sample_idx;
        load     = 1'b0;
        case (state)
            VS_IDLE, VS_DONE: begin
                if (start) begin
                    state_nx = VS_APPLY;
                    idx_nx   = 4'd0;
                    vec_nx   = VEC_TABLE[0];
                    err_nx   = {EW{1'b0}};
                    load     = 1'b1;
                end else begin
                    vec_nx = 4'd0;
                end
            end
            VS_APPLY: begin
                if (expire) begin
                    sv_nx = 1'b1;
                    sy_nx = y_in;
                    se_nx = exp_y;
                    si_nx = idx;
                    if (y_in != exp_y) begin
                        err_nx = err_count + EW'(1);
                    end else begin
                        err_nx = err_count;
                    end
                    if (idx == 4'(NUM_VEC - 1)) begin
                        state_nx = VS_DONE;
                        vec_nx   = 4'd0;
                    end else begin
                        // Next vector goes out on the sampling edge itself.
                        idx_nx = idx + 4'd1;
                        vec_nx = VEC_TABLE[idx + 4'd1];
                        load   = 1'b1;
                    end
                end else begin
                    vec_nx = vec;
                end
            end
            default: begin
                state_nx = VS_IDLE;
                vec_nx   = 4'd0;
            end
        endcase
    end

    // State and output registers; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= VS_IDLE;
            idx          <= 4'd0;
            vec          <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= {EW{1'b0}};
            sample_valid <= 1'b0;
            sample_y     <= 1'b0;
            sample_exp   <= 1'b0;
            sample_idx   <= 4'd0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            vec          <= vec_nx;
            busy         <= (state_nx == VS_APPLY);
            done         <= (state_nx == VS_DONE);
            pass         <= (state_nx == VS_DONE) && (err_nx == {EW{1'b0}});
            err_count    <= err_nx;
            sample_valid <= sv_nx;
            sample_y     <= sy_nx;
            sample_exp   <= se_nx;
            sample_idx   <= si_nx;
        end
    end

endmodule

// File: doc/vec_stepper.md
# vec_stepper

Synchronous stimulus-and-check stage wrapped around the combinational gate-timing block `y = ((a & b) | c) & d`. The block steps through a fixed table of 4-bit input vectors, holds each one for a programmable number of clock cycles so the gate network can settle, and samples the returned `y` at the end of each hold window. It compares each sample against a golden model and reports a mismatch count and a pass flag. It replaces the hand-written `#10` delay loop with synthesizable sequencing.

## Interface
- `NUM_VEC`, 4, number of table entries used (1..16).
- `HOLD_CYCLES`, 10, cycles each vector is held before sampling (≥ 2). Must exceed the network's worst-case path of 7 time units at 1 unit per cycle.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; accepted only in IDLE or DONE.
- `vec` out 4: `{a,b,c,d}` driven to the gate block; registered.
- `y_in` in 1: gate block output, sampled on the last hold cycle.
- `busy` out 1: high in APPLY.
- `done` out 1: high in DONE.
- `pass` out 1: valid in DONE; 1 iff `err_count == 0`.
- `err_count` out `$clog2(NUM_VEC+1)`: number of mismatches in the current or last run.
- `sample_valid` out 1: one-cycle pulse per sampled vector.
- `sample_y`, `sample_exp` out 1 each: sampled value and expected value, valid with `sample_valid`.
- `sample_idx` out 4: table index of the sampled vector, valid with `sample_valid`.

## Operation
- **States:** IDLE, APPLY, DONE.
- **IDLE:**
  - `vec` = 0.
  - `start` → APPLY on the next edge, with `idx` = 0, `cnt` = 0, `vec` = TABLE[0], `err_count` cleared.
- **APPLY:**
  - `cnt` increments each edge.
  - On the edge where `cnt == HOLD_CYCLES-1`:
    - Register `y_in` into `sample_y` and `exp(TABLE[idx])` into `sample_exp`.
    - Set `sample_idx` = `idx` and pulse `sample_valid` for one cycle.
    - Increment `err_count` on mismatch.
    - If `idx == NUM_VEC-1`, go to DONE.
    - Otherwise set `idx` += 1, `cnt` = 0, `vec` = TABLE[idx+1] on that same edge, with no gap cycle.
- **DONE:**
  - `vec` = 0, `done` = 1, `pass` = (`err_count` == 0), counters frozen.
  - `start` restarts exactly as from IDLE.
- **Start while busy:** `start` in APPLY is ignored.
- **Golden model:** `exp({a,b,c,d}) = ((a & b) | c) & d`.
- **Counter widths:**
  - `cnt` is wide enough for `HOLD_CYCLES-1`.
  - `err_count` cannot overflow because its width covers `NUM_VEC`; no saturation logic is needed.

## Timing
- **Reset values** (one edge after `reset` high, from any state, including mid-run):
  - State = IDLE.
  - `vec`, `busy`, `done`, `pass`, `err_count`, `sample_valid`, `sample_y`, `sample_exp`, `sample_idx` all 0.
- **Reset priority:** `reset` has priority over `start` in the same cycle.
- **Start latency:** a `start` sampled at edge E0 drives `vec` = TABLE[0] and `busy` = 1 after E0.
- **Sampling:**
  - Vector k is applied at edge E0 + k·HOLD_CYCLES.
  - `y_in` for vector k is sampled at edge E0 + (k+1)·HOLD_CYCLES.
  - `sample_valid` is high during the cycle that follows that edge.
- **Completion:** `done` rises after edge E0 + NUM_VEC·HOLD_CYCLES, in the same cycle as the final `sample_valid`. `busy` falls at that same edge.
- **`err_count` update:** `err_count` updates at the sample edge, so it is final when `done` rises.

## Structure
- **Package `vec_pkg`:**
  - State enum `vs_state_t`.
  - Constant `VEC_TABLE[16]`; entries 0..3 = `4'b1101`, `4'b0101`, `4'b1101`, `4'b1100`, remaining entries 0.
  - Function `golden_y(logic [3:0])`.
- **Sub-module `hold_timer`:**
  - Loadable down-counter.
  - Inputs `clk`, `reset`, `load`.
  - Output `expire`, a one-cycle pulse when HOLD_CYCLES have elapsed.
  - The FSM owns `idx` and the compare logic.

## Test plan
- **Correct DUT:** `start` with the gate block at delays 2/3/2 ns, 1 ns clock, HOLD_CYCLES = 10 → samples y = 1, 0, 1, 0; `err_count` = 0; `pass` = 1; `done` at 40 cycles after start.
- **Stuck-at-0 output:** `y_in` stuck at 0 → mismatches at idx 0 and idx 2; `err_count` = 2; `pass` = 0.
- **Insufficient hold:** HOLD_CYCLES = 4 with the same delayed DUT → the idx 1 sample still reads the stale 1; `err_count` ≥ 1.
- **Reset mid-run:** assert `reset` during idx 2 → next cycle `vec` = 0, `busy` = 0, `err_count` = 0, no `sample_valid`; a new `start` runs cleanly from idx 0.
- **Start while busy:** pulse `start` at cycle 15 of a run → ignored; sequence timing is unchanged.
- **Restart from DONE:** `start` in DONE → `err_count` clears, `done` drops, and the run repeats with identical results.
